stream_read_sched: RTL and testbench

Read-side scheduler for the SRAM-backed stream FIFO. It runs in the USB stream clock domain and accepts a host read request of N 16-bit words. It issues one-word read strobes with addresses to the ZBT SRAM controller while the host asserts STREAM_READY, tracks words in flight through the fixed SRAM read latency, and drives the host stream port. When the SRAM holds fewer words than requested, the remainder is filled with zero pad words, so the host always receives exactly N words.

---
 rtl/stream_read_sched.sv | 134 +++++++++++++
 tb/tb_stream_read_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_read_sched.sv
// Read-side scheduler for the SRAM-backed stream FIFO: turns a host request for N words
// into SRAM read strobes, pads with zero words when the FIFO runs dry, and drives the host port.
module stream_read_sched #(
    parameter int AW      = 19,
    parameter int LATENCY = 3,
    parameter int CW      = 24
) (
    input  logic          STREAM_CLK,
    input  logic          STREAM_RST_N,
    input  logic          REQ_VALID,
    input  logic [CW-1:0] REQ_WORDS,
    output logic          REQ_READY,
    input  logic          ABORT,
    input  logic [AW-1:0] WR_PTR,
    output logic          RD,
    output logic [AW-1:0] RD_ADDR,
    output logic [AW-1:0] RD_PTR,
    input  logic [15:0]   RD_DATA,
    input  logic          STREAM_READY,
    output logic          STREAM_WRITE_N,
    output logic [15:0]   STREAM_DATA,
    output logic [CW-1:0] REMAIN,
    output logic [AW-1:0] SIZE,
    output logic          BUSY
);

    localparam int DCW = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load_req;
    logic             issue_slot;
    logic             issue_data;
    logic [AW-1:0]    end_ptr;
    logic [DCW-1:0]   drain_cnt;
    logic [LATENCY:0] tag_valid;
    logic [LATENCY:0] tag_pad;

    assign REQ_READY  = (state == ST_IDLE);
    assign BUSY       = (state != ST_IDLE);
    assign issue_data = issue_slot && (RD_PTR != end_ptr);

    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ABORT outranks a falling STREAM_READY; the slot that empties REMAIN goes straight to DRAIN.
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        issue_slot = 1'b0;
        case (state)
            ST_IDLE: begin
                if (REQ_VALID && (REQ_WORDS != '0)) begin
                    load_req   = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ABORT) begin
                    state_next = ST_DRAIN;
                end else if (STREAM_READY) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ABORT) begin
                    state_next = ST_DRAIN;
                end else if (!STREAM_READY) begin
                    state_next = ST_WAIT;
                end else begin
                    issue_slot = 1'b1;
                    if (REMAIN == CW'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DCW'(LATENCY)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            RD             <= 1'b0;
            RD_ADDR        <= '0;
            RD_PTR         <= '0;
            REMAIN         <= '0;
            SIZE           <= '0;
            end_ptr        <= '0;
            drain_cnt      <= '0;
            tag_valid      <= '0;
            tag_pad        <= '0;
            STREAM_WRITE_N <= 1'b1;
            STREAM_DATA    <= 16'h0000;
        end else begin
            SIZE <= WR_PTR - RD_PTR;
            RD   <= issue_data;
            if (issue_data) begin
                RD_ADDR <= RD_PTR;
                RD_PTR  <= RD_PTR + AW'(1);
            end
            // END is frozen at request time so later writes never leak into this transfer.
            if (load_req) begin
                REMAIN  <= REQ_WORDS;
                end_ptr <= WR_PTR;
            end else if (issue_slot) begin
                REMAIN <= REMAIN - CW'(1);
            end
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DCW'(1) : '0;
            tag_valid <= {tag_valid[LATENCY-1:0], issue_slot};
            tag_pad   <= {tag_pad[LATENCY-1:0], issue_slot && !issue_data};
            // The last tag stage lines up with the cycle RD_DATA returns from the SRAM.
            STREAM_WRITE_N <= !tag_valid[LATENCY];
            STREAM_DATA    <= (tag_valid[LATENCY] && !tag_pad[LATENCY]) ? RD_DATA : 16'h0000;
        end
    end

endmodule

// File: tb/tb_stream_read_sched.sv
// Self-checking bench for stream_read_sched: table-driven transfers plus hand-written
// abort, busy-drop, zero-length and mid-burst reset sequences, checked by a scoreboard.
module tb_stream_read_sched;

    localparam int AW  = 4;
    localparam int LAT = 3;
    localparam int CW  = 8;

    logic          STREAM_CLK;
    logic          STREAM_RST_N;
    logic          REQ_VALID;
    logic [CW-1:0] REQ_WORDS;
    logic          REQ_READY;
    logic          ABORT;
    logic [AW-1:0] WR_PTR;
    logic          RD;
    logic [AW-1:0] RD_ADDR;
    logic [AW-1:0] RD_PTR;
    logic [15:0]   RD_DATA;
    logic          STREAM_READY;
    logic          STREAM_WRITE_N;
    logic [15:0]   STREAM_DATA;
    logic [CW-1:0] REMAIN;
    logic [AW-1:0] SIZE;
    logic          BUSY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_rd = -1;
    int first_wr = -1;

    logic [AW-1:0] m_rd_ptr;
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];

    typedef struct {
        logic [AW-1:0] wr_ptr;
        logic [CW-1:0] words;
        logic [AW-1:0] wr_after;
        int            pause_after;
        int            pause_len;
        logic [AW-1:0] exp_rd_ptr;
        logic [AW-1:0] exp_size;
    } vec_t;

    vec_t vecs[5];

    stream_read_sched #(.AW(AW), .LATENCY(LAT), .CW(CW)) dut (
        .STREAM_CLK     (STREAM_CLK),
        .STREAM_RST_N   (STREAM_RST_N),
        .REQ_VALID      (REQ_VALID),
        .REQ_WORDS      (REQ_WORDS),
        .REQ_READY      (REQ_READY),
        .ABORT          (ABORT),
        .WR_PTR         (WR_PTR),
        .RD             (RD),
        .RD_ADDR        (RD_ADDR),
        .RD_PTR         (RD_PTR),
        .RD_DATA        (RD_DATA),
        .STREAM_READY   (STREAM_READY),
        .STREAM_WRITE_N (STREAM_WRITE_N),
        .STREAM_DATA    (STREAM_DATA),
        .REMAIN         (REMAIN),
        .SIZE           (SIZE),
        .BUSY           (BUSY)
    );

    initial STREAM_CLK = 1'b0;
    always #5 STREAM_CLK = ~STREAM_CLK;

    always @(posedge STREAM_CLK) cyc <= cyc + 1;

    function automatic logic [15:0] dataOf(input logic [AW-1:0] a);
        return 16'h5A00 + 16'(a);
    endfunction

    // SRAM model: data for an RD in cycle k is presented exactly LAT cycles later.
    logic [LAT-1:0] sram_v;
    logic [AW-1:0]  sram_a[LAT];
    always @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            sram_v <= '0;
            for (int i = 0; i < LAT; i++) sram_a[i] <= '0;
        end else begin
            sram_v    <= {sram_v[LAT-2:0], RD};
            sram_a[0] <= RD_ADDR;
            for (int i = 1; i < LAT; i++) sram_a[i] <= sram_a[i-1];
        end
    end
    assign RD_DATA = sram_v[LAT-1] ? dataOf(sram_a[LAT-1]) : 16'hBEEF;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge STREAM_CLK);
        #1;
    endtask

    // Scoreboard monitor: every strobe pops one expected address or word.
    always @(negedge STREAM_CLK) begin
        if (STREAM_RST_N) begin
            if (RD) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr.size() == 0) begin
                    timeoutFail("unexpected_rd");
                end else begin
                    checkOutput("rd_addr", 32'(RD_ADDR), 32'(exp_addr.pop_front()));
                end
            end
            if (!STREAM_WRITE_N) begin
                if (first_wr < 0) first_wr = cyc;
                if (exp_data.size() == 0) begin
                    timeoutFail("unexpected_word");
                end else begin
                    checkOutput("stream_data", 32'(STREAM_DATA), 32'(exp_data.pop_front()));
                end
            end
        end
    end

    task automatic pushSlots(input int n, input logic [AW-1:0] endp);
        for (int i = 0; i < n; i++) begin
            if (m_rd_ptr != endp) begin
                exp_addr.push_back(m_rd_ptr);
                exp_data.push_back(dataOf(m_rd_ptr));
                m_rd_ptr = m_rd_ptr + 1'b1;
            end else begin
                exp_data.push_back(16'h0000);
            end
        end
    endtask

    task automatic waitRemain(input logic [CW-1:0] target);
        int n = 0;
        while (REMAIN != target && n < 300) begin
            tick();
            n++;
        end
        if (REMAIN != target) timeoutFail("wait_remain");
    endtask

    task automatic waitIdle();
        int n = 0;
        while (BUSY && n < 300) begin
            tick();
            n++;
        end
        if (BUSY) timeoutFail("wait_idle");
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(REQ_READY), 32'd1);
        checkOutput({tag, "_write_n"}, 32'(STREAM_WRITE_N), 32'd1);
        checkOutput({tag, "_rd"}, 32'(RD), 32'd0);
        checkOutput({tag, "_busy"}, 32'(BUSY), 32'd0);
        checkOutput({tag, "_rd_addr"}, 32'(RD_ADDR), 32'd0);
        checkOutput({tag, "_rd_ptr"}, 32'(RD_PTR), 32'd0);
        checkOutput({tag, "_data"}, 32'(STREAM_DATA), 32'd0);
        checkOutput({tag, "_remain"}, 32'(REMAIN), 32'd0);
        checkOutput({tag, "_size"}, 32'(SIZE), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        first_rd     = -1;
        first_wr     = -1;
        WR_PTR       = v.wr_ptr;
        REQ_WORDS    = v.words;
        REQ_VALID    = 1'b1;
        STREAM_READY = 1'b1;
        pushSlots(int'(v.words), v.wr_ptr);
        tick();
        REQ_VALID = 1'b0;
        WR_PTR    = v.wr_after;
        checkOutput("busy_after_req", 32'(BUSY), 32'd1);
        if (v.pause_after > 0) begin
            waitRemain(CW'(int'(v.words) - v.pause_after));
            STREAM_READY = 1'b0;
            repeat (v.pause_len) tick();
            checkOutput("rd_paused", 32'(RD), 32'd0);
            STREAM_READY = 1'b1;
        end
        waitIdle();
        repeat (3) tick();
    endtask

    initial begin
        vecs[0] = '{wr_ptr: 4'd8,  words: 8'd8,  wr_after: 4'd8,  pause_after: 0, pause_len: 0, exp_rd_ptr: 4'd8,  exp_size: 4'd0};
        vecs[1] = '{wr_ptr: 4'd11, words: 8'd6,  wr_after: 4'd13, pause_after: 0, pause_len: 0, exp_rd_ptr: 4'd11, exp_size: 4'd2};
        vecs[2] = '{wr_ptr: 4'd5,  words: 8'd16, wr_after: 4'd5,  pause_after: 4, pause_len: 5, exp_rd_ptr: 4'd5,  exp_size: 4'd0};
        vecs[3] = '{wr_ptr: 4'd14, words: 8'd9,  wr_after: 4'd14, pause_after: 0, pause_len: 0, exp_rd_ptr: 4'd14, exp_size: 4'd0};
        vecs[4] = '{wr_ptr: 4'd2,  words: 8'd4,  wr_after: 4'd2,  pause_after: 0, pause_len: 0, exp_rd_ptr: 4'd2,  exp_size: 4'd0};

        m_rd_ptr     = '0;
        STREAM_RST_N = 1'b0;
        REQ_VALID    = 1'b0;
        REQ_WORDS    = '0;
        ABORT        = 1'b0;
        WR_PTR       = '0;
        STREAM_READY = 1'b0;
        #12;
        checkResetValues("reset");
        tick();
        STREAM_RST_N = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_rd_ptr", i), 32'(RD_PTR), 32'(vecs[i].exp_rd_ptr));
            checkOutput($sformatf("v%0d_size", i), 32'(SIZE), 32'(vecs[i].exp_size));
            checkOutput($sformatf("v%0d_remain", i), 32'(REMAIN), 32'd0);
            checkOutput($sformatf("v%0d_req_ready", i), 32'(REQ_READY), 32'd1);
            checkOutput($sformatf("v%0d_latency", i), 32'(first_wr - first_rd), 32'(LAT + 1));
            checkOutput($sformatf("v%0d_addr_left", i), 32'(exp_addr.size()), 32'd0);
            checkOutput($sformatf("v%0d_word_left", i), 32'(exp_data.size()), 32'd0);
        end

        // Abort after 5 of 20 slots: in-flight words still arrive, REMAIN is kept.
        begin
            int n = 0;
            WR_PTR       = 4'd12;
            REQ_WORDS    = 8'd20;
            REQ_VALID    = 1'b1;
            STREAM_READY = 1'b1;
            pushSlots(5, 4'd12);
            tick();
            REQ_VALID = 1'b0;
            waitRemain(8'd15);
            ABORT = 1'b1;
            tick();
            ABORT = 1'b0;
            while (BUSY && n < 50) begin
                tick();
                n++;
            end
            checkOutput("abort_drain_cycles", 32'(n), 32'(LAT + 1));
            checkOutput("abort_remain", 32'(REMAIN), 32'd15);
            checkOutput("abort_req_ready", 32'(REQ_READY), 32'd1);
            checkOutput("abort_rd_ptr", 32'(RD_PTR), 32'd7);
            repeat (3) tick();
            checkOutput("abort_word_left", 32'(exp_data.size()), 32'd0);
        end

        // Zero-length request is ignored.
        REQ_WORDS = 8'd0;
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        checkOutput("zero_busy", 32'(BUSY), 32'd0);
        repeat (4) tick();
        checkOutput("zero_rd_ptr", 32'(RD_PTR), 32'd7);

        // A second request while busy is dropped, not queued.
        WR_PTR    = 4'd10;
        REQ_WORDS = 8'd3;
        REQ_VALID = 1'b1;
        pushSlots(3, 4'd10);
        tick();
        REQ_WORDS = 8'd5;
        WR_PTR    = 4'd15;
        tick();
        tick();
        REQ_VALID = 1'b0;
        waitIdle();
        repeat (3) tick();
        checkOutput("busyreq_rd_ptr", 32'(RD_PTR), 32'd10);
        checkOutput("busyreq_size", 32'(SIZE), 32'd5);
        checkOutput("busyreq_busy_after", 32'(BUSY), 32'd0);
        checkOutput("busyreq_word_left", 32'(exp_data.size()), 32'd0);

        // Reset in the middle of a burst.
        WR_PTR    = 4'd4;
        REQ_WORDS = 8'd10;
        REQ_VALID = 1'b1;
        pushSlots(10, 4'd4);
        tick();
        REQ_VALID = 1'b0;
        waitRemain(8'd6);
        STREAM_RST_N = 1'b0;
        #1;
        checkResetValues("midreset");
        exp_addr.delete();
        exp_data.delete();
        m_rd_ptr = '0;
        tick();
        STREAM_RST_N = 1'b1;
        repeat (8) tick();
        checkOutput("post_reset_busy", 32'(BUSY), 32'd0);
        checkOutput("post_reset_rd_ptr", 32'(RD_PTR), 32'd0);
        checkOutput("post_reset_size", 32'(SIZE), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
